// File: rtl/bloke2b_digest_sink.sv
`default_nettype none
// ============================================================================
//  Module   : bloke2b_digest_sink
//  Purpose  : Receiving end of the bloke2b byte-serial output stream. Shifts
//             incoming digest bytes into a right-aligned parallel register,
//             counts them (saturating), flags overflow, and on end-of-message
//             registers a compare against an expected digest/length.
//  Ports    : clk, rst              - clock, synchronous active-high reset
//             start                 - clears the sink and arms capture
//             din/din_valid/din_end - core output stream (no backpressure)
//             exp_digest, exp_len   - expected digest (right-aligned) / length
//             digest, byte_count    - captured digest / accepted byte count
//             busy, done, match     - collecting / finished / compare result
//             overflow              - sticky, more than DIGEST_BYTES received
//  Revision : 1.0 - initial release
// ============================================================================
module bloke2b_digest_sink #(
   parameter int DIGEST_BYTES = 64,
   parameter int CNT_W        = 7
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [7:0]                din,
   input  logic                      din_valid,
   input  logic                      din_end,
   input  logic [8*DIGEST_BYTES-1:0] exp_digest,
   input  logic [CNT_W-1:0]          exp_len,
   output logic [8*DIGEST_BYTES-1:0] digest,
   output logic [CNT_W-1:0]          byte_count,
   output logic                      busy,
   output logic                      done,
   output logic                      match,
   output logic                      overflow
);

   localparam int               W       = 8 * DIGEST_BYTES;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DIGEST_BYTES);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t state;

   // Values the capture registers take at this edge if a byte is accepted.
   // The compare uses them so a byte arriving with din_end is included.
   logic [W-1:0]            cap_digest;
   logic [CNT_W-1:0]        cap_count;
   logic                    cap_ovf;
   logic                    cap_match;
   logic                    len_ok;
   logic                    bytes_eq;
   logic [DIGEST_BYTES-1:0] byte_en;
   logic [W-1:0]            len_mask;

   // Only the low exp_len bytes take part in the compare.
   generate
      for (genvar i = 0; i < DIGEST_BYTES; i++) begin : g_mask
         assign byte_en[i]         = (exp_len > CNT_W'(i));
         assign len_mask[8*i +: 8] = {8{byte_en[i]}};
      end
   endgenerate

   always_comb begin
      cap_digest = digest;
      cap_count  = byte_count;
      cap_ovf    = overflow;
      if (din_valid) begin
         cap_digest = {digest[W-9:0], din};
         if (byte_count < MAX_CNT) begin
            cap_count = byte_count + CNT_W'(1);
         end else begin
            // Register already full: oldest byte falls off the top.
            cap_ovf = 1'b1;
         end
      end
      len_ok    = (exp_len != '0) && (exp_len <= MAX_CNT);
      bytes_eq  = ((cap_digest ^ exp_digest) & len_mask) == '0;
      cap_match = len_ok && (cap_count == exp_len) && bytes_eq && !cap_ovf;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         digest     <= '0;
         byte_count <= '0;
         overflow   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         match      <= 1'b0;
      end else if (start) begin
         // start outranks din_valid/din_end in every state, including an
         // abort of a message still being collected.
         state      <= S_COLLECT;
         digest     <= '0;
         byte_count <= '0;
         overflow   <= 1'b0;
         busy       <= 1'b1;
         done       <= 1'b0;
         match      <= 1'b0;
      end else begin
         case (state)
            S_COLLECT: begin
               digest     <= cap_digest;
               byte_count <= cap_count;
               overflow   <= cap_ovf;
               if (din_end) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  match <= cap_match;
               end
            end
            S_IDLE, S_DONE: begin
               // Stream inputs ignored; all outputs hold.
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
               match <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/bloke2b_digest_sink.md
Name: bloke2b_digest_sink

Overview:
- Receiving end of the bloke2b output stream. Captures the byte-serial digest from the dout/dout_valid/dout_end interface into a parallel register.
- Counts the received bytes and compares the digest against an expected value.
- Sits between the bloke2b core and the checker/CSR logic. The core has no output backpressure, so the sink is always ready.

Parameters:
- DIGEST_BYTES, 64, maximum digest length in bytes; register width is 8*DIGEST_BYTES.
- CNT_W, 7, byte counter width; must hold DIGEST_BYTES, i.e. CNT_W = clog2(DIGEST_BYTES+1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse, same cycle as the core's start; clears the sink and arms capture.
- din  in  8  byte from core dout.
- din_valid  in  1  core dout_valid; din is valid this cycle.
- din_end  in  1  core dout_end; the message is complete. May coincide with the last din_valid or follow it.
- exp_digest  in  8*DIGEST_BYTES  expected digest, right-aligned (last byte in [7:0]); sampled at end.
- exp_len  in  CNT_W  expected byte count, 1..DIGEST_BYTES.
- digest  out  8*DIGEST_BYTES  captured digest, right-aligned, most recent byte in [7:0].
- byte_count  out  CNT_W  bytes accepted since start, saturating at DIGEST_BYTES.
- busy  out  1  high in COLLECT.
- done  out  1  high in DONE; held until start or rst.
- match  out  1  compare result; valid only while done=1, else 0.
- overflow  out  1  sticky: more than DIGEST_BYTES bytes were received since start.

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; digest=0, byte_count=0, busy=0, done=0, match=0, overflow=0. Reset wins over every other input, including mid-collection.
- States: IDLE, COLLECT, DONE.
- IDLE:
  - din_valid and din_end are ignored.
  - start -> COLLECT; digest, byte_count, overflow are cleared.
- COLLECT:
  - busy=1.
  - On din_valid: digest <= {digest[8*DIGEST_BYTES-9:0], din}.
  - On din_valid with byte_count < DIGEST_BYTES: byte_count increments.
  - On din_valid with byte_count == DIGEST_BYTES: byte_count holds, overflow <= 1, and the oldest byte is shifted out.
  - On din_end: go to DONE. If din_valid is high in the same cycle, that byte is captured first and is included in the compare.
- Compare, registered on the transition into DONE:
  - match = (final count == exp_len) && (the low 8*exp_len bits of the final digest equal the low 8*exp_len bits of exp_digest) && !final overflow.
  - Bits above exp_len bytes are don't-care.
  - exp_len = 0 or exp_len > DIGEST_BYTES forces match = 0.
- Latency: din_end at edge N -> done=1 and match valid after edge N (visible in cycle N+1). busy falls at that same edge.
- DONE:
  - busy=0, done=1; digest, byte_count, match, overflow are frozen.
  - din_valid and din_end are ignored.
  - start -> COLLECT, with the same clearing as from IDLE; done and match drop in the next cycle.
- start has priority over din_valid and din_end in every state. A byte arriving in the start cycle is discarded.
- start during COLLECT aborts and restarts capture; no done is produced for the aborted message.
- din_end alone in COLLECT with zero bytes -> DONE, byte_count=0, match=0.
- Back-to-back din_valid every cycle is accepted without stalls.

Test Plan:
- Reset then start, then 64 bytes 0x00..0x3F, din_end with the last byte; exp_len=64, exp_digest=0x00..0x3F -> byte_count=64, digest[7:0]=0x3F, digest[511:504]=0x00, done=1 and match=1 one cycle after end.
- Same stream with exp_digest byte 0 flipped (0x3F->0xBF) -> done=1, match=0, overflow=0.
- start, then 3 bytes 0x61,0x62,0x63, din_end one idle cycle after the last byte; exp_len=3, exp_digest low bytes 0x616263, upper bits 0xFF filler -> byte_count=3, digest=0x...616263, match=1.
- start, 65 bytes 0x01..0x41, din_end -> byte_count=64, overflow=1, digest[7:0]=0x41, digest[511:504]=0x02, match=0 even with exp_digest equal to the captured bits.
- start, 10 bytes, start again with din_valid high in the same cycle (byte 0xAA), then 2 bytes 0x11,0x22 + din_end -> byte_count=2, digest low 16 bits=0x1122, 0xAA absent, exactly one done.
- rst asserted mid-COLLECT after 5 bytes -> next cycle all outputs 0, state IDLE. A following din_valid/din_end without start leaves done=0 and byte_count=0.
